oddr_pattern_gen: RTL and testbench
===================================

# oddr_pattern_gen

Parametrised multi-channel pattern source for ODDR output testing. Generates a rising-edge/falling-edge data pair per channel every `clk` cycle for ODDR primitives in the top level, plus a per-channel output-enable for the bidirectional pads. It adds four selectable patterns, a programmable rate divider, burst/continuous runs, and a start/stop/done handshake over the earlier single-channel enable-only test generator. It sits between the VIO/control logic and the ODDR/IOBUF instances, in the `clk` domain.

## Interface
- `NUM_CH`, 4: number of output channels (1..32).
- `DIV_W`, 8: width of the rate-divider input.
- `LEN_W`, 16: width of the burst-length input.

- `clk`  in  1  fabric clock that also drives the ODDRs.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  level. Low forces IDLE immediately, with no `done`.
- `start`  in  1  single-cycle pulse that begins a run.
- `stop`  in  1  single-cycle pulse that aborts a run.
- `mode`  in  2  0 CLK_FWD, 1 TOGGLE, 2 PRBS7, 3 WALK.
- `div`  in  DIV_W  pattern advances every `div+1` beats (TOGGLE/WALK only).
- `burst_len`  in  LEN_W  beats per run. 0 means continuous.
- `ch_en`  in  NUM_CH  channel mask.
- `d_rise`  out  NUM_CH  ODDR D1 data.
- `d_fall`  out  NUM_CH  ODDR D2 data.
- `oe`  out  NUM_CH  pad output-enable, high = drive.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- Reset: all outputs are 0, FSM is IDLE, the PRBS register is 7'h7F, and all counters are 0.
- FSM has two states:
  - IDLE → RUN on `start & enable & !stop`.
  - RUN → IDLE when the last beat completes (`burst_len` ≠ 0), on `stop`, or on `!enable`.
- `mode`, `div`, `burst_len` and `ch_en` are latched at start. Changes during RUN are ignored.
- `start` during RUN is ignored. If `start` and `stop` arrive in the same IDLE cycle, `stop` wins and nothing starts.
- Per beat in RUN, for enabled channel k (disabled channels drive d_rise=d_fall=oe=0):
  - CLK_FWD: `d_rise=1`, `d_fall=0`. This forwards `clk`.
  - TOGGLE: `d_rise=d_fall=lvl`. `lvl` starts at 1 and inverts after every `div+1` beats.
  - PRBS7: polynomial x^7+x^6+1. The shift is `s ← {s[5:0], s[6]^s[5]}`. `d_rise=s[6]`, `d_fall=step(s)[6]`, then `s ← step(step(s))`. Seed 7'h7F is reloaded at every start. All channels carry the same bits.
  - WALK: `d_rise=d_fall=1` only on channel `idx`. `idx` starts at 0 and advances modulo NUM_CH every `div+1` beats. Disabled channels still consume their slot.
- `oe = ch_en_latched` while `busy`, else 0.
- `done` pulses for natural completion and for `stop`. It does not pulse for `!enable` or `rst`.
- The beat counter is LEN_W bits wide. In continuous mode it is not compared.
- Divider counter: it counts from 0 to `div`, then wraps and advances the pattern. `div` = all-ones is legal.

## Timing
- All outputs are registered.
- Latency: if `start` is sampled at edge N, then after edge N `busy=1`, `oe` is valid, and beat 0 appears on `d_rise/d_fall`.
- A burst of L beats keeps `busy` high for exactly L cycles. After the edge ending beat L−1, `busy=0`, data/oe=0 and `done=1` for one cycle.
- If `stop` is sampled at edge M during RUN, then after edge M data/oe=0, `busy=0` and `done=1`. A `stop` on the final beat's edge gives a single `done`.
- `!enable` is sampled the same way as `stop`, but `done` stays 0.
- A new `start` is accepted on the edge where `done` is high. The next run's beat 0 follows with no gap cycle.
- Asserting `rst` mid-run clears outputs asynchronously. Release is synchronous to `clk` at the top level.

## Structure
- Package `oddr_pkg` holds:
  - `mode_e` (CLK_FWD, TOGGLE, PRBS7, WALK)
  - `state_e` (IDLE, RUN)
  - `PRBS7_SEED = 7'h7F`
  - `PRBS7_TAPS`
- Sub-module `prbs7_2x` takes clk, rst, load and advance, and outputs `bit_r` and `bit_f`. It produces two bits per cycle.
- The FSM, counters and output registers live in `oddr_pattern_gen`.

## Test plan
- CLK_FWD, ch_en=4'b1011, burst_len=5, start at cycle 10:
  - cycles 11–15: busy=1, d_rise=4'b1011, d_fall=0, oe=4'b1011.
  - cycle 16: done=1, all else 0.
- TOGGLE, div=2, burst_len=9: lvl sequence over beats is 1,1,1,0,0,0,1,1,1, then done.
- PRBS7, burst_len=0, all channels:
  - beats 0–2: rise=fall=1.
  - beat 3: rise=1, fall=0.
  - stop at beat 6: done pulses once and outputs return to 0.
- WALK, NUM_CH=4, div=0, ch_en=4'b1101: beats 0..4 give d_rise = 0001, 0000, 0100, 1000, 0001.
- Edge cases:
  - start+stop in the same IDLE cycle → no busy, no done.
  - start during RUN → no effect.
  - start on the done cycle → next beat 0 follows immediately.
  - enable dropped mid-run → busy=0 next cycle, done=0.
  - rst mid-burst → all outputs 0 immediately; the following start reloads PRBS seed 7'h7F.

Source files
------------

// File: rtl/oddr_pkg.sv
// Shared types and PRBS7 constants for the ODDR pattern source.
// The PRBS7 step is kept here so the generator and sub-module agree.
package oddr_pkg;

  typedef enum logic [1:0] {
    CLK_FWD = 2'd0,
    TOGGLE  = 2'd1,
    PRBS7   = 2'd2,
    WALK    = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b1100000;

  // x^7 + x^6 + 1, shifting towards the MSB
  function automatic logic [6:0] prbs7_step(
    input logic [6:0] s
  );
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction

endpackage

// File: rtl/prbs7_2x.sv
// Two-bits-per-cycle PRBS7 source; bits reflect the seed in the load cycle
// so the first beat of a run can be registered on the start edge.
module prbs7_2x
  import oddr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic advance,
  output logic bit_r,
  output logic bit_f
);

  logic [6:0] s;
  logic [6:0] cur;
  logic [6:0] mid;

  always_comb begin
    cur = load ? PRBS7_SEED : s;
    mid = prbs7_step(cur);
  end

  assign bit_r = cur[6];
  assign bit_f = mid[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= PRBS7_SEED;
    end else if (load | advance) begin
      s <= prbs7_step(mid);
    end
  end

endmodule

// File: rtl/oddr_pattern_gen.sv
// Multi-channel ODDR pattern source: rise/fall data pair and output-enable
// per channel, with selectable pattern, rate divider and burst control.
module oddr_pattern_gen
  import oddr_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] d_rise,
  output logic [NUM_CH-1:0] d_fall,
  output logic [NUM_CH-1:0] oe,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  state_e state;
  state_e state_n;

  mode_e             mode_l;
  logic [DIV_W-1:0]  div_l;
  logic [LEN_W-1:0]  len_l;
  logic [NUM_CH-1:0] ch_l;

  logic [LEN_W-1:0]  cnt;
  logic [DIV_W-1:0]  dcnt;
  logic              lvl;
  logic [IDX_W-1:0]  idx;

  logic go;
  logic last;
  logic load;
  logic cont;
  logic emit;
  logic done_n;
  logic adv;
  logic prbs_r;
  logic prbs_f;

  mode_e             m_eff;
  logic [NUM_CH-1:0] ch_eff;
  logic [DIV_W-1:0]  dcnt_b;
  logic              lvl_b;
  logic [IDX_W-1:0]  idx_b;
  logic [NUM_CH-1:0] walk_b;
  logic [NUM_CH-1:0] rise_n;
  logic [NUM_CH-1:0] fall_n;

  assign go   = start & enable & ~stop;
  assign last = (len_l != '0) && (cnt == len_l);

  prbs7_2x u_prbs (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (cont),
    .bit_r   (prbs_r),
    .bit_f   (prbs_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (go) state_n = RUN;
      RUN:     if (stop | ~enable | last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    load   = (state == IDLE) & go;
    cont   = (state == RUN) & enable & ~stop & ~last;
    emit   = load | cont;
    done_n = (state == RUN) & enable & (stop | last);
    m_eff  = load ? mode_e'(mode) : mode_l;
    ch_eff = load ? ch_en : ch_l;
    adv    = (dcnt == div_l);
    // beat 0 of a run always starts from a fresh divider/level/index
    if (load) begin
      dcnt_b = '0;
      lvl_b  = 1'b1;
      idx_b  = '0;
    end else if (adv) begin
      dcnt_b = '0;
      lvl_b  = ~lvl;
      idx_b  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      dcnt_b = dcnt + 1'b1;
      lvl_b  = lvl;
      idx_b  = idx;
    end
    walk_b        = '0;
    walk_b[idx_b] = 1'b1;
    rise_n = '0;
    fall_n = '0;
    unique case (1'b1)
      (m_eff == CLK_FWD): begin
        rise_n = '1;
        fall_n = '0;
      end
      (m_eff == TOGGLE): begin
        rise_n = {NUM_CH{lvl_b}};
        fall_n = {NUM_CH{lvl_b}};
      end
      (m_eff == PRBS7): begin
        rise_n = {NUM_CH{prbs_r}};
        fall_n = {NUM_CH{prbs_f}};
      end
      default: begin
        rise_n = walk_b;
        fall_n = walk_b;
      end
    endcase
    rise_n = rise_n & ch_eff;
    fall_n = fall_n & ch_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_l <= CLK_FWD;
      div_l  <= '0;
      len_l  <= '0;
      ch_l   <= '0;
      cnt    <= '0;
      dcnt   <= '0;
      lvl    <= 1'b0;
      idx    <= '0;
      d_rise <= '0;
      d_fall <= '0;
      oe     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (load) begin
        mode_l <= mode_e'(mode);
        div_l  <= div;
        len_l  <= burst_len;
        ch_l   <= ch_en;
      end
      if (emit) begin
        cnt  <= load ? LEN_W'(1) : cnt + 1'b1;
        dcnt <= dcnt_b;
        lvl  <= lvl_b;
        idx  <= idx_b;
      end
      d_rise <= emit ? rise_n : '0;
      d_fall <= emit ? fall_n : '0;
      oe     <= emit ? ch_eff : '0;
      busy   <= emit;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_oddr_pattern_gen.sv
// Scoreboard bench for oddr_pattern_gen: expected outputs are queued as
// stimulus is driven and compared just after the following clock edge.
module tb_oddr_pattern_gen;

  typedef struct packed {
    logic       b;
    logic       d;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] o;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [7:0]  div;
  logic [15:0] burst_len;
  logic [3:0]  ch_en;
  logic [3:0]  d_rise;
  logic [3:0]  d_fall;
  logic [3:0]  oe;
  logic        busy;
  logic        done;

  obs_t obs;
  obs_t sb[$];
  string tq[$];
  int n_chk = 0;
  int n_pass = 0;

  localparam obs_t IDLE_O = '0;
  localparam obs_t DONE_O = 14'b01_0000_0000_0000;

  always #5 clk = ~clk;

  assign obs = {busy, done, d_rise, d_fall, oe};

  oddr_pattern_gen #(
    .NUM_CH (4),
    .DIV_W  (8),
    .LEN_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .div       (div),
    .burst_len (burst_len),
    .ch_en     (ch_en),
    .d_rise    (d_rise),
    .d_fall    (d_fall),
    .oe        (oe),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    obs_t  e;
    string t;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      t = tq.pop_front();
      check(t, 32'(obs), 32'(e));
    end
  end

  function automatic obs_t ob(
    input logic       b,
    input logic       d,
    input logic [3:0] r,
    input logic [3:0] f,
    input logic [3:0] o
  );
    return {b, d, r, f, o};
  endfunction

  function automatic logic [6:0] st7(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  task automatic drive(
    input logic  st,
    input logic  sp,
    input logic  en,
    input obs_t  e,
    input string tag
  );
    @(negedge clk);
    start  = st;
    stop   = sp;
    enable = en;
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic cfg(
    input logic [1:0]  m,
    input logic [7:0]  dv,
    input logic [15:0] l,
    input logic [3:0]  c
  );
    mode      = m;
    div       = dv;
    burst_len = l;
    ch_en     = c;
  endtask

  // PRBS7 beats 0..n-1 from the seed, starting a run on beat 0
  task automatic prbs_run(input int n, input string tag);
    logic [6:0] s;
    logic [6:0] t;
    s = 7'h7F;
    for (int k = 0; k < n; k++) begin
      t = st7(s);
      drive(k == 0, 1'b0, 1'b1,
            ob(1'b1, 1'b0, {4{s[6]}}, {4{t[6]}}, 4'hF), tag);
      s = st7(t);
    end
  endtask

  initial begin
    logic [3:0] wk [5];
    logic [3:0] v;
    wk = '{4'b0001, 4'b0000, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1;
    enable = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg(2'd0, 8'd0, 16'd0, 4'h0);
    @(posedge clk);
    #1 check("reset", 32'(obs), 32'(IDLE_O));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b1, IDLE_O, "idle");

    // CLK_FWD burst of 5 on a sparse mask
    cfg(2'd0, 8'd0, 16'd5, 4'b1011);
    for (int k = 0; k < 5; k++)
      drive(k == 0, 1'b0, 1'b1,
            ob(1'b1, 1'b0, 4'b1011, 4'b0000, 4'b1011), "cf_beat");
    drive(1'b0, 1'b0, 1'b1, DONE_O, "cf_done");
    drive(1'b0, 1'b0, 1'b1, IDLE_O, "cf_after");

    // TOGGLE div=2 with ignored config changes and a stray start
    cfg(2'd1, 8'd2, 16'd9, 4'hF);
    for (int k = 0; k < 9; k++) begin
      if (k == 4) cfg(2'd0, 8'd0, 16'd3, 4'h1);
      v = (((k / 3) % 2) == 0) ? 4'hF : 4'h0;
      drive((k == 0) || (k == 5), 1'b0, 1'b1,
            ob(1'b1, 1'b0, v, v, 4'hF), "tg_beat");
    end
    cfg(2'd2, 8'd0, 16'd0, 4'hF);
    drive(1'b0, 1'b0, 1'b1, DONE_O, "tg_done");

    // PRBS7 continuous, started on the done cycle, stopped after beat 6
    prbs_run(7, "pr_beat");
    drive(1'b0, 1'b1, 1'b1, DONE_O, "pr_stop");
    drive(1'b0, 1'b0, 1'b1, IDLE_O, "pr_idle");

    // WALK div=0 over a mask with a hole
    cfg(2'd3, 8'd0, 16'd5, 4'b1101);
    for (int k = 0; k < 5; k++)
      drive(k == 0, 1'b0, 1'b1,
            ob(1'b1, 1'b0, wk[k], wk[k], 4'b1101), "wk_beat");
    drive(1'b0, 1'b0, 1'b1, DONE_O, "wk_done");

    // start and stop together in IDLE
    drive(1'b1, 1'b1, 1'b1, IDLE_O, "ss_nostart");
    drive(1'b0, 1'b0, 1'b1, IDLE_O, "ss_nodone");

    // enable dropped mid-run
    cfg(2'd0, 8'd0, 16'd0, 4'hF);
    drive(1'b1, 1'b0, 1'b1, ob(1'b1, 1'b0, 4'hF, 4'h0, 4'hF), "en_b0");
    drive(1'b0, 1'b0, 1'b1, ob(1'b1, 1'b0, 4'hF, 4'h0, 4'hF), "en_b1");
    drive(1'b0, 1'b0, 1'b0, IDLE_O, "en_drop");
    drive(1'b0, 1'b0, 1'b1, IDLE_O, "en_nodone");

    // reset mid-burst, then the next run must restart from the seed
    cfg(2'd2, 8'd0, 16'd0, 4'hF);
    prbs_run(3, "rs_pre");
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("rst_async", 32'(obs), 32'(IDLE_O));
    @(negedge clk);
    rst = 1'b0;
    prbs_run(4, "rs_reseed");
    drive(1'b0, 1'b1, 1'b1, DONE_O, "rs_stop");
    drive(1'b0, 1'b0, 1'b1, IDLE_O, "rs_idle");

    repeat (2) @(posedge clk);
    #2 check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
